// File: rtl/fpnew_writeback_buffer.sv
// rtl/fpnew_writeback_buffer.sv - in-order FPU result buffer with sticky fflags accumulation
// Optional macro FPNEW_WB_BYPASS_EN: combinational fall-through when the buffer is empty.
module fpnew_writeback_buffer #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4,
  parameter type TagType = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [Width-1:0]           result_i,
  input  logic [4:0]                 status_i,
  input  logic [$bits(TagType)-1:0]  tag_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [Width-1:0]           result_o,
  output logic [4:0]                 status_o,
  output logic [$bits(TagType)-1:0]  tag_o,
  output logic [4:0]                 fflags_o,
  input  logic                       fflags_clr_i,
  output logic [$clog2(Depth+1)-1:0] usage_o,
  output logic                       busy_o
);

  localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned UW = $clog2(Depth + 1);
  localparam int unsigned TW = $bits(TagType);
  localparam logic [PW-1:0] LastIdx = PW'(Depth - 1);
  localparam logic [UW-1:0] FullCnt = UW'(Depth);

  logic [Width-1:0] r_result [Depth];
  logic [4:0]       r_status [Depth];
  logic [TW-1:0]    r_tag    [Depth];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [UW-1:0]    r_usage;
  logic [4:0]       r_fflags;

  logic w_empty;
  logic w_push;
  logic w_store;
  logic w_pop;

  // Handshake is derived from registered occupancy only, so the writeback stall never reaches the FPU.
  assign w_empty    = (r_usage == '0);
  assign in_ready_o = (r_usage != FullCnt);
  assign w_push     = in_valid_i && in_ready_o;
  assign w_pop      = !w_empty && out_ready_i;

`ifdef FPNEW_WB_BYPASS_EN
  logic w_bypass;
  assign w_bypass    = w_empty && in_valid_i;
  assign w_store     = w_push && !(w_bypass && out_ready_i);
  assign out_valid_o = !w_empty || in_valid_i;
  assign result_o    = w_bypass ? result_i : r_result[r_rptr];
  assign status_o    = w_bypass ? status_i : r_status[r_rptr];
  assign tag_o       = w_bypass ? tag_i    : r_tag[r_rptr];
`else
  assign w_store     = w_push;
  assign out_valid_o = !w_empty;
  assign result_o    = r_result[r_rptr];
  assign status_o    = r_status[r_rptr];
  assign tag_o       = r_tag[r_rptr];
`endif

  assign fflags_o = r_fflags;
  assign usage_o  = r_usage;
  assign busy_o   = !w_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_usage  <= '0;
      r_fflags <= '0;
    end else begin
      if (flush_i) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_usage <= '0;
      end else begin
        if (w_store) r_wptr <= (r_wptr == LastIdx) ? '0 : r_wptr + PW'(1);
        if (w_pop)   r_rptr <= (r_rptr == LastIdx) ? '0 : r_rptr + PW'(1);
        case ({w_store, w_pop})
          2'b10:   r_usage <= r_usage + UW'(1);
          2'b01:   r_usage <= r_usage - UW'(1);
          default: ;
        endcase
      end
      // Flags accumulate at acceptance, even for a push that a flush then discards.
      if (fflags_clr_i)  r_fflags <= w_push ? status_i : 5'b0;
      else if (w_push)   r_fflags <= r_fflags | status_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_store && !flush_i) begin
      r_result[r_wptr] <= result_i;
      r_status[r_wptr] <= status_i;
      r_tag[r_wptr]    <= tag_i;
    end
  end

  a_no_overflow:  assert property (@(posedge clk_i) disable iff (!rst_ni) !(w_store && r_usage == FullCnt));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(w_pop && w_empty));

endmodule

// File: tb/tb_fpnew_writeback_buffer.sv
// tb/tb_fpnew_writeback_buffer.sv - scoreboard bench for fpnew_writeback_buffer
module tb_fpnew_writeback_buffer;

`ifdef FPNEW_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [63:0] r;
    logic [4:0]  s;
    logic [3:0]  t;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] result = '0;
  logic [4:0]  status = '0;
  logic [3:0]  tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result_o;
  logic [4:0]  status_o;
  logic [3:0]  tag_o;
  logic [4:0]  fflags;
  logic        fclr = 1'b0;
  logic [2:0]  usage;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;
  entry_t q[$];

  always #5 clk = ~clk;

  fpnew_writeback_buffer #(.Width(64), .Depth(4), .TagType(logic [3:0])) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .result_i(result), .status_i(status), .tag_i(tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result_o), .status_o(status_o), .tag_o(tag_o),
    .fflags_o(fflags), .fflags_clr_i(fclr),
    .usage_o(usage), .busy_o(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every output handshake against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (flush) begin
        q.delete();
      end else if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output_tag", {60'b0, tag_o}, 64'hFFFF);
        end else begin
          entry_t e;
          e = q.pop_front();
          chk("out_result", result_o, e.r);
          chk("out_status", {59'b0, status_o}, {59'b0, e.s});
          chk("out_tag", {60'b0, tag_o}, {60'b0, e.t});
        end
      end
    end
  end

  task automatic step(input bit v, input logic [63:0] r, input logic [4:0] s, input logic [3:0] t,
                      input bit ordy, input bit fl, input bit clr, input bit acc);
    entry_t e;
    in_valid = v; result = r; status = s; tag = t;
    out_ready = ordy; flush = fl; fclr = clr;
    if (v) begin
      chk("in_ready", {63'b0, in_ready}, {63'b0, acc});
      if (acc) begin
        e.r = r; e.s = s; e.t = t;
        q.push_back(e);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; fclr = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_usage", {61'b0, usage}, 64'd0);
    chk("rst_fflags", {59'b0, fflags}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single push, visible the next cycle
    step(1, 64'h3FF0_0000_0000_0000, 5'b00001, 4'd1, 1, 0, 0, 1);
    chk("t1_usage", {61'b0, usage}, BYP ? 64'd0 : 64'd1);
    chk("t1_out_valid", {63'b0, out_valid}, BYP ? 64'd0 : 64'd1);
    chk("t1_fflags", {59'b0, fflags}, 64'h01);
    step(0, '0, '0, '0, 1, 0, 0, 0);
    chk("t1_usage_after", {61'b0, usage}, 64'd0);
    chk("t1_busy_after", {63'b0, busy}, 64'd0);

    // 2: fill to Depth with writeback stalled, fifth push refused
    for (int i = 0; i < 5; i++)
      step(1, 64'h1000 + 64'(i), 5'b0, 4'(i), 0, 0, 0, i < 4);
    chk("t2_usage_full", {61'b0, usage}, 64'd4);
    chk("t2_in_ready_full", {63'b0, in_ready}, 64'd0);
    chk("t2_head_stable", {60'b0, tag_o}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain_valid", {63'b0, out_valid}, 64'd1);
      step(0, '0, '0, '0, 1, 0, 0, 0);
    end
    chk("t2_usage_empty", {61'b0, usage}, 64'd0);

    // 3: steady-state push+pop at usage 2 across pointer wrap
    step(1, 64'hA8, 5'b0, 4'd8, 0, 0, 0, 1);
    step(1, 64'hA9, 5'b0, 4'd9, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step(1, 64'hB0 + 64'(i), 5'b0, 4'(10 + i), 1, 0, 0, 1);
      chk("t3_usage_steady", {61'b0, usage}, 64'd2);
    end
    step(0, '0, '0, '0, 1, 0, 0, 0);
    step(0, '0, '0, '0, 1, 0, 0, 0);
    chk("t3_usage_empty", {61'b0, usage}, 64'd0);

    // 4: sticky flags and clear-then-accumulate
    step(0, '0, '0, '0, 0, 0, 1, 0);
    chk("t4_fflags_clr", {59'b0, fflags}, 64'd0);
    step(1, 64'hC1, 5'b10000, 4'd2, 1, 0, 0, 1);
    chk("t4_fflags_a", {59'b0, fflags}, 64'h10);
    step(1, 64'hC2, 5'b00100, 4'd3, 1, 0, 1, 1);
    chk("t4_fflags_b", {59'b0, fflags}, 64'h04);
    step(0, '0, '0, '0, 1, 0, 0, 0);
    chk("t4_usage_empty", {61'b0, usage}, 64'd0);

    // 5: flush with a pop and an accepted push in the same cycle
    for (int i = 1; i <= 3; i++)
      step(1, 64'hD0 + 64'(i), 5'b00010, 4'(i), 0, 0, 0, 1);
    chk("t5_usage3", {61'b0, usage}, 64'd3);
    chk("t5_fflags_pre", {59'b0, fflags}, 64'h06);
    step(1, 64'hDF, 5'b01000, 4'd4, 1, 1, 0, 1);
    chk("t5_out_valid_flush", {63'b0, out_valid}, 64'd0);
    chk("t5_usage_flush", {61'b0, usage}, 64'd0);
    chk("t5_fflags_flush", {59'b0, fflags}, 64'h0E);
    step(1, 64'hE7, 5'b0, 4'd7, 0, 0, 0, 1);
    chk("t5_head_tag7", {60'b0, tag_o}, 64'd7);
    step(0, '0, '0, '0, 1, 0, 0, 0);
    chk("t5_usage_end", {61'b0, usage}, 64'd0);

`ifdef FPNEW_WB_BYPASS_EN
    // 6: zero-latency fall-through when empty
    begin
      entry_t e;
      in_valid = 1'b1; result = 64'hF5; status = 5'b00001; tag = 4'd5; out_ready = 1'b1;
      e.r = 64'hF5; e.s = 5'b00001; e.t = 4'd5;
      q.push_back(e);
      #1;
      chk("t6_bypass_valid", {63'b0, out_valid}, 64'd1);
      chk("t6_bypass_tag", {60'b0, tag_o}, 64'd5);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("t6_usage", {61'b0, usage}, 64'd0);
      chk("t6_fflags", {59'b0, fflags}, 64'h0F);
    end
`endif

    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpnew_writeback_buffer.md
Name: fpnew_writeback_buffer

Overview:
- Result buffer directly downstream of the FPU top-level output handshake (result/status/tag, valid/ready).
- Decouples the FPU arbiter from a stalling integer-core writeback port, so that port's ready never has to propagate into the FPU combinationally.
- Stores up to Depth completed results in order.
- Accumulates accepted status flags into a sticky fflags register for the core's CSR.

Parameters:
Width, 64, result width; matches the FPU datapath width.
Depth, 4, number of buffered entries; legal range >= 2, need not be a power of two.
TagType, logic, tag type carried unchanged alongside each result.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  reset, asynchronous, active-low.
flush_i  in  1  discard all buffered entries.
in_valid_i  in  1  upstream result valid.
in_ready_o  out  1  buffer can accept an entry.
result_i  in  Width  upstream result.
status_i  in  5  upstream status {NV,DZ,OF,UF,NX}.
tag_i  in  $bits(TagType)  upstream tag.
out_valid_o  out  1  head entry valid.
out_ready_i  in  1  writeback consumes head.
result_o  out  Width  head result.
status_o  out  5  head status.
tag_o  out  $bits(TagType)  head tag.
fflags_o  out  5  sticky accumulated status.
fflags_clr_i  in  1  clear sticky flags.
usage_o  out  $clog2(Depth+1)  occupied entries.
busy_o  out  1  buffer non-empty.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset values:
  - Pointers, usage_o and fflags_o = 0.
  - out_valid_o = 0; in_ready_o = 1; busy_o = 0.
  - Storage contents are don't-care. Reset mid-transfer drops all entries immediately.
- Storage: circular array of Depth entries {result, status, tag}.
  - Write and read pointers advance by 1 and wrap from Depth-1 to 0.
  - Occupancy counter ranges 0..Depth.
- Push: occurs when in_valid_i && in_ready_o at a rising edge.
  - Entry is written at the write pointer.
  - in_ready_o = (usage != Depth). It is registered-state-only: no combinational path from out_ready_i or in_valid_i.
- Pop: occurs when out_valid_o && out_ready_i.
  - out_valid_o = (usage != 0).
  - result_o, status_o and tag_o come from the head entry and are stable while out_valid_o && !out_ready_i.
- Simultaneous push and pop: usage is unchanged and both pointers advance.
  - Legal whenever 0 < usage < Depth.
  - When full, no push is possible (in_ready_o = 0), so only the pop occurs.
  - When empty, only the push occurs (no fall-through in the default build).
- Latency: a pushed entry appears on the outputs no earlier than the cycle after acceptance (1-cycle minimum).
- Flags: on every accepted push, fflags <= fflags | status_i. Flags accumulate at acceptance, not at pop.
  - fflags_clr_i without a push: fflags <= 0.
  - fflags_clr_i in the same cycle as a push: fflags <= status_i (clear then accumulate).
  - Flush does not change fflags.
- Flush: flush_i at a rising edge empties the buffer: pointers = 0, usage = 0, out_valid_o = 0 the next cycle.
  - A push or pop in the flush cycle is discarded and has no effect on storage.
  - Status from a push discarded by flush is still OR'd into fflags only if it was accepted; since in_ready_o is state-based, an accepted push during flush does update fflags.
- Status checks: usage_o and busy_o = (usage != 0) are registered-state derived.
- Overflow/underflow: impossible by construction. An assertion must flag any push while full or pop while empty.

Optional Feature:
- Macro: FPNEW_WB_BYPASS_EN.
- Defined (fall-through when empty):
  - out_valid_o = in_valid_i and outputs = inputs combinationally.
  - If out_ready_i is also high, the entry is consumed without being stored (0-cycle latency); fflags still accumulate status_i.
  - If out_ready_i is low, the entry is stored normally.
  - in_ready_o remains state-only.
- Undefined: strictly registered behaviour as above; minimum latency 1 cycle.

Test Plan:
1. Reset, then push result 64'h3FF0_0000_0000_0000, status 5'b00001, tag 1 with out_ready_i=1 → out_valid_o rises the next cycle with identical data; fflags_o = 5'b00001; usage_o returns to 0 after the pop.
2. Depth=4, out_ready_i=0, push 5 back-to-back entries → first 4 accepted, in_ready_o = 0 after the 4th, usage_o = 4. Then drain with out_ready_i=1 → tags come out in push order 0,1,2,3, one per cycle.
3. usage=2, simultaneous push and pop for 6 cycles → usage_o stays 2, pointers wrap past index 3, output order preserved.
4. Push status 5'b10000, then in one cycle push status 5'b00100 with fflags_clr_i=1 → fflags_o = 5'b10000, then 5'b00100.
5. usage=3, assert flush_i alongside a pop → next cycle out_valid_o = 0, usage_o = 0, fflags_o unchanged. Subsequent push of tag 7 is output first.
6. With FPNEW_WB_BYPASS_EN, when empty: in_valid_i=1, out_ready_i=1, tag 5 → out_valid_o=1 with tag 5 in the same cycle; usage_o stays 0.
